// File: rtl/sram_access_arbiter_if.sv
// SRAM access arbiter bus bundle: CPU and video request/response handshakes
// plus the SRAM pin-side signals (DQ tri-state split into in/out/enable).
// The slave modport is taken by the arbiter; the master modport by whatever
// drives the requests and terminates the SRAM pins.
interface sram_access_arbiter_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 16
);
    logic              CPU_Req;
    logic              CPU_R_W;
    logic [15:0]       CPU_Addr;
    logic [DATA_W-1:0] CPU_WData;
    logic [DATA_W-1:0] CPU_RData;
    logic              CPU_Ready;

    logic              Vid_Req;
    logic [ADDR_W-1:0] Vid_Addr;
    logic [DATA_W-1:0] Vid_RData;
    logic              Vid_Valid;

    logic              Busy;

    logic [ADDR_W-1:0] SRAM_ADDR;
    logic [DATA_W-1:0] SRAM_DQ_In;
    logic [DATA_W-1:0] SRAM_DQ_Out;
    logic              SRAM_DQ_OE;
    logic              SRAM_CE_N;
    logic              SRAM_OE_N;
    logic              SRAM_WE_N;
    logic              SRAM_LB_N;
    logic              SRAM_UB_N;

    modport slave (
        input  CPU_Req, CPU_R_W, CPU_Addr, CPU_WData,
        output CPU_RData, CPU_Ready,
        input  Vid_Req, Vid_Addr,
        output Vid_RData, Vid_Valid,
        output Busy,
        output SRAM_ADDR, SRAM_DQ_Out, SRAM_DQ_OE,
        output SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_LB_N, SRAM_UB_N,
        input  SRAM_DQ_In
    );

    modport master (
        output CPU_Req, CPU_R_W, CPU_Addr, CPU_WData,
        input  CPU_RData, CPU_Ready,
        output Vid_Req, Vid_Addr,
        input  Vid_RData, Vid_Valid,
        input  Busy,
        input  SRAM_ADDR, SRAM_DQ_Out, SRAM_DQ_OE,
        input  SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_LB_N, SRAM_UB_N,
        output SRAM_DQ_In
    );
endinterface

// File: rtl/sram_access_arbiter.sv
// SRAM access arbiter: shares one asynchronous SRAM between the CPU memory
// path and the video fetch path, sequencing IDLE -> SETUP -> ACCESS -> HOLD
// with fully registered chip controls and DQ tri-state enable.
// Build option: define SRAM_ARB_VID_PRIORITY_EN to make video win every tie
// in IDLE; otherwise ties are resolved round-robin on the last grant.
module sram_access_arbiter #(
    parameter int ADDR_W      = 20,
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = 2
) (
    input logic                    Clk,
    input logic                    Reset,
    sram_access_arbiter_if.slave   bus_if
);

    if (WAIT_CYCLES < 1) begin : g_bad_wait
        $error("sram_access_arbiter: WAIT_CYCLES must be at least 1");
    end
    if (ADDR_W < 16) begin : g_bad_addr
        $error("sram_access_arbiter: ADDR_W must be at least 16");
    end

    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        HOLD
    } state_t;

    state_t             state, state_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic               op_wr, wr_d;
    logic               gnt_vid, vid_d;
    logic               pick_vid;
    logic [ADDR_W-1:0]  addr_d;
    logic [DATA_W-1:0]  wdata_d;
    logic [DATA_W-1:0]  cpu_rdata_d, vid_rdata_d;
    logic               ce_n_d, oe_n_d, we_n_d, dq_oe_d;
    logic               cpu_rdy_d, vid_val_d, busy_d;
`ifndef SRAM_ARB_VID_PRIORITY_EN
    logic               last_vid, last_d;
`endif

    // Next-state, latch and capture logic; outputs are decoded from the
    // state being entered so every pin is a flop that matches its state.
    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        wr_d        = op_wr;
        vid_d       = gnt_vid;
        addr_d      = bus_if.SRAM_ADDR;
        wdata_d     = bus_if.SRAM_DQ_Out;
        cpu_rdata_d = bus_if.CPU_RData;
        vid_rdata_d = bus_if.Vid_RData;
        pick_vid    = 1'b0;
`ifndef SRAM_ARB_VID_PRIORITY_EN
        last_d      = last_vid;
`endif

        case (state)
            IDLE: begin
                if (bus_if.CPU_Req && bus_if.Vid_Req) begin
`ifdef SRAM_ARB_VID_PRIORITY_EN
                    pick_vid = 1'b1;
`else
                    pick_vid = ~last_vid;
`endif
                end else begin
                    pick_vid = bus_if.Vid_Req;
                end
                if (bus_if.CPU_Req || bus_if.Vid_Req) begin
                    state_d = SETUP;
                    vid_d   = pick_vid;
`ifndef SRAM_ARB_VID_PRIORITY_EN
                    last_d  = pick_vid;
`endif
                    if (pick_vid) begin
                        addr_d = bus_if.Vid_Addr;
                        wr_d   = 1'b0;
                    end else begin
                        addr_d  = ADDR_W'(bus_if.CPU_Addr);
                        wr_d    = bus_if.CPU_R_W;
                        wdata_d = bus_if.CPU_WData;
                    end
                end
            end
            SETUP: begin
                state_d = ACCESS;
                cnt_d   = CNT_W'(WAIT_CYCLES - 1);
            end
            ACCESS: begin
                if (cnt == '0) begin
                    state_d = HOLD;
                    if (!op_wr) begin
                        if (gnt_vid) vid_rdata_d = bus_if.SRAM_DQ_In;
                        else         cpu_rdata_d = bus_if.SRAM_DQ_In;
                    end
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end
            HOLD: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ce_n_d    = 1'b1;
        oe_n_d    = 1'b1;
        we_n_d    = 1'b1;
        dq_oe_d   = 1'b0;
        cpu_rdy_d = 1'b0;
        vid_val_d = 1'b0;
        busy_d    = (state_d != IDLE);
        case (state_d)
            SETUP: begin
                ce_n_d  = 1'b0;
                dq_oe_d = wr_d;
            end
            ACCESS: begin
                ce_n_d  = 1'b0;
                oe_n_d  = wr_d;
                we_n_d  = ~wr_d;
                dq_oe_d = wr_d;
            end
            HOLD: begin
                ce_n_d    = 1'b0;
                dq_oe_d   = wr_d;
                cpu_rdy_d = ~vid_d;
                vid_val_d = vid_d;
            end
            default: begin
            end
        endcase
    end

    // State, sequencing registers and all registered outputs; reset aborts
    // any access in flight without issuing a completion pulse.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state              <= IDLE;
            cnt                <= '0;
            op_wr              <= 1'b0;
            gnt_vid            <= 1'b0;
`ifndef SRAM_ARB_VID_PRIORITY_EN
            last_vid           <= 1'b0;
`endif
            bus_if.SRAM_ADDR   <= '0;
            bus_if.SRAM_DQ_Out <= '0;
            bus_if.SRAM_DQ_OE  <= 1'b0;
            bus_if.SRAM_CE_N   <= 1'b1;
            bus_if.SRAM_OE_N   <= 1'b1;
            bus_if.SRAM_WE_N   <= 1'b1;
            bus_if.SRAM_LB_N   <= 1'b1;
            bus_if.SRAM_UB_N   <= 1'b1;
            bus_if.CPU_RData   <= '0;
            bus_if.Vid_RData   <= '0;
            bus_if.CPU_Ready   <= 1'b0;
            bus_if.Vid_Valid   <= 1'b0;
            bus_if.Busy        <= 1'b0;
        end else begin
            state              <= state_d;
            cnt                <= cnt_d;
            op_wr              <= wr_d;
            gnt_vid            <= vid_d;
`ifndef SRAM_ARB_VID_PRIORITY_EN
            last_vid           <= last_d;
`endif
            bus_if.SRAM_ADDR   <= addr_d;
            bus_if.SRAM_DQ_Out <= wdata_d;
            bus_if.SRAM_DQ_OE  <= dq_oe_d;
            bus_if.SRAM_CE_N   <= ce_n_d;
            bus_if.SRAM_OE_N   <= oe_n_d;
            bus_if.SRAM_WE_N   <= we_n_d;
            bus_if.SRAM_LB_N   <= ce_n_d;
            bus_if.SRAM_UB_N   <= ce_n_d;
            bus_if.CPU_RData   <= cpu_rdata_d;
            bus_if.Vid_RData   <= vid_rdata_d;
            bus_if.CPU_Ready   <= cpu_rdy_d;
            bus_if.Vid_Valid   <= vid_val_d;
            bus_if.Busy        <= busy_d;
        end
    end

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Self-checking bench for sram_access_arbiter: directed scenarios followed by
// random CPU/video traffic, scored against a transaction-level model (grant
// order, completion latency, strobe cycle counts, read data from a reference
// memory). A second instance with WAIT_CYCLES = 1 checks back-to-back rate.
module tb_sram_access_arbiter;

    localparam int W = 2;

    logic        Clk   = 1'b0;
    logic        Reset = 1'b0;
    int unsigned tests = 0;
    int unsigned fails = 0;

    sram_access_arbiter_if #(.ADDR_W(20), .DATA_W(16)) bus_if ();
    sram_access_arbiter_if #(.ADDR_W(20), .DATA_W(16)) bus1_if ();

    sram_access_arbiter #(.ADDR_W(20), .DATA_W(16), .WAIT_CYCLES(W)) dut (
        .Clk    (Clk),
        .Reset  (Reset),
        .bus_if (bus_if)
    );

    sram_access_arbiter #(.ADDR_W(20), .DATA_W(16), .WAIT_CYCLES(1)) dut1 (
        .Clk    (Clk),
        .Reset  (Reset),
        .bus_if (bus1_if)
    );

    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Content an untouched SRAM location returns.
    function automatic logic [15:0] init_pat(input logic [19:0] a);
        logic [15:0] lo;
        lo = a[15:0];
        return lo ^ {a[19:16], 12'h000} ^ 16'hA5A5;
    endfunction

    // Behavioural SRAM chip on the main instance's pins.
    logic [15:0] sram_mem [int unsigned];
    always @(negedge Clk) begin
        if (!bus_if.SRAM_CE_N && !bus_if.SRAM_WE_N && bus_if.SRAM_DQ_OE)
            sram_mem[bus_if.SRAM_ADDR] = bus_if.SRAM_DQ_Out;
        if (!bus_if.SRAM_CE_N && !bus_if.SRAM_OE_N)
            bus_if.SRAM_DQ_In = sram_mem.exists(bus_if.SRAM_ADDR) ?
                                sram_mem[bus_if.SRAM_ADDR] : init_pat(bus_if.SRAM_ADDR);
        else
            bus_if.SRAM_DQ_In = 16'h0000;
    end

    // Second instance: read data is a fixed function of the address.
    assign bus1_if.SRAM_DQ_In = bus1_if.SRAM_ADDR[15:0] ^ 16'h5A5A;

    // Pin-level safety rules on both instances.
    always @(negedge Clk) begin
        if (Reset === 1'b1) begin
            check_eq("oe_we_both_low", {31'd0, !bus_if.SRAM_OE_N && !bus_if.SRAM_WE_N}, 0);
            check_eq("dq_oe_during_read", {31'd0, bus_if.SRAM_DQ_OE && !bus_if.SRAM_OE_N}, 0);
            check_eq("dq_oe_in_idle", {31'd0, bus_if.SRAM_DQ_OE && !bus_if.Busy}, 0);
            check_eq("w1_oe_we_both_low", {31'd0, !bus1_if.SRAM_OE_N && !bus1_if.SRAM_WE_N}, 0);
            check_eq("w1_dq_oe_during_read", {31'd0, bus1_if.SRAM_DQ_OE && !bus1_if.SRAM_OE_N}, 0);
        end
    end

    // Reference model state.
    logic [15:0] ref_mem [int unsigned];
    bit          last_vid_m  = 1'b0;
    logic [15:0] exp_cpu_rd  = '0;
    logic [15:0] exp_vid_rd  = '0;

    function automatic logic [15:0] ref_rd(input logic [19:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_pat(a);
    endfunction

    task automatic reset_pulse();
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        Reset = 1'b1;
        last_vid_m = 1'b0;
        exp_cpu_rd = '0;
        exp_vid_rd = '0;
    endtask

    // One arbitration round: present the requests in IDLE and score every
    // access it produces against the model.
    task automatic run_txn(input bit c_req, input bit c_wr, input logic [15:0] c_addr,
                           input logic [15:0] c_wd, input bit v_req, input logic [19:0] v_addr);
        bit          vid_first, both, do_vid;
        int          first_at, second_at, last_n, n_rd, n_wr;
        int          c_at, v_at, c_hi, v_hi, oe_lo, we_lo, dq_hi;
        logic [19:0] c_addr20, a_first, a_second;
        if (!c_req && !v_req) return;
        both = c_req && v_req;
`ifdef SRAM_ARB_VID_PRIORITY_EN
        vid_first = v_req;
`else
        vid_first = both ? !last_vid_m : v_req;
`endif
        c_addr20  = {4'h0, c_addr};
        a_first   = vid_first ? v_addr : c_addr20;
        a_second  = vid_first ? c_addr20 : v_addr;
        first_at  = W + 2;
        second_at = 2 * W + 5;
        last_n    = both ? second_at : first_at;
        last_vid_m = both ? !vid_first : vid_first;
        n_wr = (c_req && c_wr) ? 1 : 0;
        n_rd = (v_req ? 1 : 0) + ((c_req && !c_wr) ? 1 : 0);

        @(negedge Clk);
        bus_if.CPU_Req   = c_req;
        bus_if.CPU_R_W   = c_wr;
        bus_if.CPU_Addr  = c_addr;
        bus_if.CPU_WData = c_wd;
        bus_if.Vid_Req   = v_req;
        bus_if.Vid_Addr  = v_addr;

        c_at = 0; v_at = 0; c_hi = 0; v_hi = 0; oe_lo = 0; we_lo = 0; dq_hi = 0;
        for (int n = 1; n <= last_n + 1; n++) begin
            @(posedge Clk);
            #1;
            if (n == 1) check_eq("addr_first_grant", {12'd0, bus_if.SRAM_ADDR}, {12'd0, a_first});
            if (both && n == W + 4)
                check_eq("addr_second_grant", {12'd0, bus_if.SRAM_ADDR}, {12'd0, a_second});
            if (!bus_if.SRAM_OE_N) oe_lo++;
            if (!bus_if.SRAM_WE_N) we_lo++;
            if (bus_if.SRAM_DQ_OE) dq_hi++;
            if (bus_if.CPU_Ready) begin
                c_hi++;
                if (c_at == 0) c_at = n;
                bus_if.CPU_Req = 1'b0;
            end
            if (bus_if.Vid_Valid) begin
                v_hi++;
                if (v_at == 0) v_at = n;
                bus_if.Vid_Req = 1'b0;
            end
        end
        bus_if.CPU_Req = 1'b0;
        bus_if.Vid_Req = 1'b0;

        check_eq("cpu_ready_cycles", c_hi, c_req ? 1 : 0);
        check_eq("vid_valid_cycles", v_hi, v_req ? 1 : 0);
        if (c_req) check_eq("cpu_latency", c_at, vid_first ? second_at : first_at);
        if (v_req) check_eq("vid_latency", v_at, vid_first ? first_at : second_at);
        check_eq("oe_n_low_cycles", oe_lo, W * n_rd);
        check_eq("we_n_low_cycles", we_lo, W * n_wr);
        check_eq("dq_oe_cycles", dq_hi, (W + 2) * n_wr);

        for (int s = 0; s < 2; s++) begin
            do_vid = ((s == 0) == vid_first);
            if (do_vid && v_req) exp_vid_rd = ref_rd(v_addr);
            if (!do_vid && c_req) begin
                if (c_wr) ref_mem[c_addr20] = c_wd;
                else      exp_cpu_rd = ref_rd(c_addr20);
            end
        end
        check_eq("cpu_rdata", {16'd0, bus_if.CPU_RData}, {16'd0, exp_cpu_rd});
        check_eq("vid_rdata", {16'd0, bus_if.Vid_RData}, {16'd0, exp_vid_rd});
    endtask

    initial begin
        int          hi, got, n, last;
        logic [15:0] a1, exp1_rd;
        logic [19:0] va;

        bus_if.CPU_Req = 0; bus_if.CPU_R_W = 0; bus_if.CPU_Addr = '0; bus_if.CPU_WData = '0;
        bus_if.Vid_Req = 0; bus_if.Vid_Addr = '0; bus_if.SRAM_DQ_In = '0;
        bus1_if.CPU_Req = 0; bus1_if.CPU_R_W = 0; bus1_if.CPU_Addr = '0; bus1_if.CPU_WData = '0;
        bus1_if.Vid_Req = 0; bus1_if.Vid_Addr = '0;

        // Reset values while reset is held.
        #12;
        check_eq("rst_ctrl_n", {27'd0, bus_if.SRAM_CE_N, bus_if.SRAM_OE_N, bus_if.SRAM_WE_N,
                                bus_if.SRAM_LB_N, bus_if.SRAM_UB_N}, 32'h1F);
        check_eq("rst_dq_oe", {31'd0, bus_if.SRAM_DQ_OE}, 0);
        check_eq("rst_addr", {12'd0, bus_if.SRAM_ADDR}, 0);
        check_eq("rst_dq_out", {16'd0, bus_if.SRAM_DQ_Out}, 0);
        check_eq("rst_rdata", {bus_if.CPU_RData, bus_if.Vid_RData}, 0);
        check_eq("rst_pulses_busy", {29'd0, bus_if.CPU_Ready, bus_if.Vid_Valid, bus_if.Busy}, 0);
        @(negedge Clk);
        Reset = 1'b1;

        // Reset mid-ACCESS of a write aborts asynchronously.
        @(negedge Clk);
        bus_if.CPU_Req = 1; bus_if.CPU_R_W = 1; bus_if.CPU_Addr = 16'h7FFF; bus_if.CPU_WData = 16'h1234;
        @(posedge Clk);
        @(posedge Clk);
        #3;
        check_eq("abort_pre_we_n", {31'd0, bus_if.SRAM_WE_N}, 0);
        Reset = 1'b0;
        #1;
        check_eq("abort_we_n", {31'd0, bus_if.SRAM_WE_N}, 1);
        check_eq("abort_ce_n", {31'd0, bus_if.SRAM_CE_N}, 1);
        check_eq("abort_dq_oe", {31'd0, bus_if.SRAM_DQ_OE}, 0);
        bus_if.CPU_Req = 0;
        @(negedge Clk);
        Reset = 1'b1;
        hi = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge Clk);
            #1;
            if (bus_if.CPU_Ready) hi++;
        end
        check_eq("abort_no_ready", hi, 0);
        check_eq("abort_busy", {31'd0, bus_if.Busy}, 0);
        sram_mem.delete();
        ref_mem.delete();
        last_vid_m = 1'b0;

        // Directed: CPU write then read back, video read.
        run_txn(1, 1, 16'h3000, 16'hBEEF, 0, 20'h0);
        run_txn(1, 0, 16'h3000, 16'h0000, 0, 20'h0);
        check_eq("cpu_read_beef", {16'd0, bus_if.CPU_RData}, 32'hBEEF);
        run_txn(0, 0, 16'h0000, 16'h0000, 1, 20'h4B000);

        // Ties straight after reset.
        reset_pulse();
        run_txn(1, 0, 16'h3001, 16'h0000, 1, 20'h4B001);
        run_txn(1, 1, 16'h3002, 16'hCAFE, 1, 20'h4B002);

        // Random traffic.
        for (int k = 0; k < 80; k++) begin
            repeat ($urandom_range(0, 2)) @(posedge Clk);
            va = ($urandom_range(0, 1) == 1) ? {16'h0300, 4'($urandom)} : {16'h4B00, 4'($urandom)};
            case ($urandom_range(0, 3))
                0:       run_txn(1, 1'($urandom), {12'h300, 4'($urandom)}, 16'($urandom), 0, va);
                1:       run_txn(0, 0, 16'h0000, 16'h0000, 1, va);
                default: run_txn(1, 1'($urandom), {12'h300, 4'($urandom)}, 16'($urandom), 1, va);
            endcase
        end

        // WAIT_CYCLES = 1 instance: back-to-back CPU accesses.
        a1 = 16'($urandom);
        exp1_rd = '0;
        @(negedge Clk);
        bus1_if.CPU_Req = 1; bus1_if.CPU_R_W = 0; bus1_if.CPU_Addr = a1; bus1_if.CPU_WData = 16'($urandom);
        n = 0;
        last = 0;
        for (int k = 0; k < 8; k++) begin
            got = 0;
            for (int t = 0; t < 12 && got == 0; t++) begin
                @(posedge Clk);
                #1;
                n++;
                if (bus1_if.CPU_Ready) got = 1;
            end
            check_eq("w1_ready_seen", got, 1);
            check_eq("w1_spacing", n - last, (k == 0) ? 3 : 4);
            last = n;
            if (!bus1_if.CPU_R_W) exp1_rd = a1 ^ 16'h5A5A;
            check_eq("w1_cpu_rdata", {16'd0, bus1_if.CPU_RData}, {16'd0, exp1_rd});
            a1 = 16'($urandom);
            bus1_if.CPU_Addr  = a1;
            bus1_if.CPU_R_W   = 1'($urandom);
            bus1_if.CPU_WData = 16'($urandom);
        end
        bus1_if.CPU_Req = 0;
        repeat (4) @(posedge Clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sram_access_arbiter.md
Name: sram_access_arbiter

Overview:
- Sequences every physical SRAM cycle and shares the single SRAM chip between two requesters:
  - the CPU memory path, downstream of memory-mapped I/O decode;
  - the video fetch path, which reads display data.
- Converts simple request/ready handshakes into correctly timed active-low chip controls and tri-state control for the DQ bus.
- Sits between the memory control unit / video controller and the top-level SRAM pins.

Parameters:
- ADDR_W, 20, SRAM word-address width.
- DATA_W, 16, SRAM data width.
- WAIT_CYCLES, 2, cycles that OE_N/WE_N are held active per access. Minimum 1; a value of 0 is an elaboration error.

Ports:
- Clk  in  1  system clock; all state on rising edge.
- Reset  in  1  asynchronous, active-low reset (0 = reset).
- CPU_Req  in  1  CPU access request; held with CPU_R_W/CPU_Addr/CPU_WData stable until CPU_Ready.
- CPU_R_W  in  1  1 = write, 0 = read.
- CPU_Addr  in  16  CPU word address; zero-extended to ADDR_W.
- CPU_WData  in  DATA_W  CPU write data.
- CPU_RData  out  DATA_W  registered CPU read data.
- CPU_Ready  out  1  one-cycle completion pulse for CPU access.
- Vid_Req  in  1  video read request; held with Vid_Addr stable until Vid_Valid.
- Vid_Addr  in  ADDR_W  video read address.
- Vid_RData  out  DATA_W  registered video read data.
- Vid_Valid  out  1  one-cycle completion pulse for video read.
- Busy  out  1  high whenever state != IDLE.
- SRAM_ADDR  out  ADDR_W  chip address.
- SRAM_DQ_In  in  DATA_W  data from DQ tri-state.
- SRAM_DQ_Out  out  DATA_W  data to DQ tri-state.
- SRAM_DQ_OE  out  1  1 = drive DQ.
- SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_LB_N, SRAM_UB_N  out  1 each  active-low chip controls.

Behaviour:
- All outputs are registered.
- Reset values:
  - state IDLE;
  - all *_N outputs = 1;
  - SRAM_DQ_OE = 0;
  - SRAM_ADDR = 0, SRAM_DQ_Out = 0;
  - CPU_RData = Vid_RData = 0;
  - CPU_Ready = Vid_Valid = Busy = 0;
  - last-grant flag = CPU, so video wins the first tie.
- Reset asserted mid-access aborts immediately (asynchronously): controls return to reset values; no Ready/Valid is issued.
- States: IDLE -> SETUP (1 cycle) -> ACCESS (WAIT_CYCLES cycles, down-counter) -> HOLD (1 cycle) -> IDLE. There is no other path out of any state except reset.
- IDLE: requests are sampled. Arbitration:
  - only one requester asserted -> grant it;
  - both asserted -> grant the requester not granted last (round-robin);
  - last-grant flag updates on every grant;
  - neither asserted -> stay in IDLE.
- On grant, address and write data are latched into SRAM_ADDR/SRAM_DQ_Out; the op type is latched. Requester inputs are ignored until the next IDLE.
- SETUP:
  - CE_N = LB_N = UB_N = 0; OE_N = WE_N = 1;
  - SRAM_DQ_OE = 1 for writes only.
- ACCESS:
  - read: OE_N = 0; data captured from SRAM_DQ_In into the granted port's RData register at the edge ending the last ACCESS cycle;
  - write: WE_N = 0; DQ driven.
- HOLD:
  - OE_N = WE_N = 1; CE/LB/UB remain 0;
  - write data remains driven (hold time);
  - granted port's Ready/Valid = 1 for exactly this cycle.
- Latency: request sampled at IDLE edge t -> Ready/Valid high during cycle t+2+WAIT_CYCLES. Default is 4 cycles.
- Minimum spacing is one IDLE cycle between accesses; peak rate is one access per 3+WAIT_CYCLES cycles.
- SRAM_DQ_OE is never 1 in IDLE or on any read cycle. OE_N and WE_N are never simultaneously 0.
- Each RData register changes only on its own port's read capture; CPU writes leave CPU_RData unchanged.
- Vid_Valid never pulses for a CPU access, and CPU_Ready never pulses for a video access.

Optional Feature:
- Macro SRAM_ARB_VID_PRIORITY_EN.
- Defined: video always wins a tie in IDLE; the last-grant flag is unused.
  - Required for glitch-free scan-out when the CPU issues back-to-back accesses.
- Undefined: round-robin as specified above.
- Handshake, timing and latency are identical in both builds.

Test Plan:
- Reset low mid-ACCESS of a write -> WE_N/CE_N = 1 and SRAM_DQ_OE = 0 asynchronously; no CPU_Ready pulse; after release, state IDLE with Busy = 0.
- CPU write 0xBEEF to 0x3000, then CPU read of 0x3000 with the SRAM model returning 0xBEEF:
  - SRAM_ADDR = 0x03000;
  - WE_N low for exactly 2 cycles;
  - CPU_Ready 4 cycles after request;
  - CPU_RData = 0xBEEF; Vid_RData unchanged.
- Video read of 0x4B000 -> OE_N low for 2 cycles, DQ_OE = 0 throughout, Vid_Valid single pulse, Vid_RData = model data.
- CPU and video request in the same cycle after reset:
  - default build: grant order is video, then CPU, then video;
  - with SRAM_ARB_VID_PRIORITY_EN and continuous Vid_Req: CPU is never granted.
- WAIT_CYCLES = 1 with back-to-back CPU requests -> one access per 4 cycles; OE_N and WE_N are never both 0; DQ_OE never high during OE_N = 0.
